// File: rtl/audio_pkg.sv
// audio_pkg: constants and saturation helper shared by the audio output stage
package audio_pkg;
  localparam int GAIN_MAX = 16;
  localparam int BEEP_MID = 128;
  localparam int PCM_W = 16;
  function automatic logic signed [PCM_W-1:0] sat18to16(input logic signed [17:0] x);
    return (x > 18'sd32767) ? 16'sh7fff : (x < -18'sd32768) ? 16'sh8000 : $signed(x[PCM_W-1:0]);
  endfunction
endpackage

// File: rtl/sd_mod1.sv
// sd_mod1: first-order sigma-delta modulator, carry of the phase accumulator is the bit
module sd_mod1 import audio_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [PCM_W-1:0] pcm,
  output logic             dac_out
);
  logic [PCM_W:0] acc_d, acc_q;
  always_comb acc_d = {1'b0, acc_q[PCM_W-1:0]} + {1'b0, pcm ^ 16'h8000};
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign dac_out = acc_q[PCM_W];
endmodule

// File: rtl/audio_sd_dac.sv
// audio_sd_dac: mixes beep and audio with volume and soft-mute ramp, drives a 1-bit sigma-delta pin
module audio_sd_dac import audio_pkg::*; #(
  parameter int WIN_LOG2   = 5,
  parameter int BEEP_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio,
  input  logic        audio_valid,
  input  logic [7:0]  beep,
  input  logic        beep_on,
  input  logic [3:0]  volume,
  input  logic        mute,
  output logic        dac_out,
  output logic        clip,
  output logic [15:0] pcm
);
  localparam int AW = WIN_LOG2 + 8;
  logic [WIN_LOG2-1:0] cnt_d, cnt_q;
  logic [AW-1:0] acc_d, acc_q, acc_sum;
  logic [7:0] beep_avg_d, beep_avg_q;
  logic [15:0] audio_held_d, audio_held_q, audio_snap_d, audio_snap_q;
  logic [1:0] tick_d, tick_q;
  logic signed [15:0] mix_d, mix_q, scaled;
  logic signed [17:0] b, sum;
  logic signed [20:0] prod;
  logic [4:0] g_d, g_q;
  logic [15:0] pcm_d, pcm_q;
  logic clip_d, clip_q, tick;
  always_comb begin
    tick = &cnt_q;
    cnt_d = cnt_q + WIN_LOG2'(1);
    acc_sum = acc_q + AW'(beep);
    acc_d = tick ? '0 : acc_sum;
    beep_avg_d = tick ? acc_sum[AW-1 -: 8] : beep_avg_q;
    audio_held_d = audio_valid ? audio : audio_held_q;
    // snapshot at the tick so a coincident strobe lands in the next window
    audio_snap_d = tick ? audio_held_q : audio_snap_q;
    tick_d = {tick_q[0], tick};
    scaled = $signed(audio_snap_q) >>> (4'd15 - volume);
    b = beep_on ? (18'($signed({1'b0, beep_avg_q})) - 18'sd128) <<< BEEP_SHIFT : 18'sd0;
    sum = 18'(scaled) + b;
    mix_d = tick_q[0] ? sat18to16(sum) : mix_q;
    clip_d = tick_q[0] && (18'(sat18to16(sum)) != sum);
    g_d = !tick ? g_q
        : (!mute && g_q < 5'(GAIN_MAX)) ? g_q + 5'd1
        : (mute && g_q != 5'd0) ? g_q - 5'd1 : g_q;
    prod = 21'(mix_q) * 21'($signed({1'b0, g_q}));
    pcm_d = tick_q[1] ? 16'(prod >>> 4) : pcm_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      beep_avg_q <= 8'(BEEP_MID);
      audio_held_q <= '0;
      audio_snap_q <= '0;
      tick_q <= '0;
      mix_q <= '0;
      clip_q <= 1'b0;
      g_q <= '0;
      pcm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      beep_avg_q <= beep_avg_d;
      audio_held_q <= audio_held_d;
      audio_snap_q <= audio_snap_d;
      tick_q <= tick_d;
      mix_q <= mix_d;
      clip_q <= clip_d;
      g_q <= g_d;
      pcm_q <= pcm_d;
    end
  sd_mod1 u_sd (.clk(clk), .rst(rst), .pcm(pcm_q), .dac_out(dac_out));
  assign clip = clip_q;
  assign pcm = pcm_q;
endmodule

// File: doc/audio_sd_dac.md
# audio_sd_dac

Audio output stage of the SDR receiver. Consumes the 8-bit modulated tone from the beeper and the signed 16-bit demodulated audio. Mixes them with volume and a soft-mute gain ramp, then drives a single board pin through a first-order sigma-delta modulator. It sits directly downstream of the beeper; its 1-bit output goes straight to the RC-filtered audio pin.

## Interface
Parameters:
- WIN_LOG2, 5: log2 of the beep averaging window and mix tick period, in clocks. The default window is 32 clocks, one beeper carrier period.
- BEEP_SHIFT, 6: left shift applied to the centred beep average before mixing.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-low
- audio  in  16  signed demodulated audio sample
- audio_valid  in  1  one-clock strobe; captures `audio`
- beep  in  8  unsigned beeper output, one value per clock
- beep_on  in  1  enables the beep in the mix
- volume  in  4  audio volume; 15 = full scale, 0 = quietest
- mute  in  1  level; requests ramp to silence
- dac_out  out  1  sigma-delta bitstream
- clip  out  1  one-clock pulse when the mix saturated on a tick
- pcm  out  16  signed gained sample fed to the modulator (debug/verification)

## Operation
- **Window counter** (WIN_LOG2 bits): increments every clock and wraps. The tick is the clock on which the counter equals all-ones.
- **Beep accumulator** (WIN_LOG2+8 bits):
  - Adds `beep` every clock.
  - On the tick, `beep_avg` takes accumulator_final[top 8 bits], i.e. the sum including the tick clock's sample, divided by 2^WIN_LOG2.
  - On the same tick the accumulator reloads with 0, so the next window starts clean.
- **Audio hold**: `audio_held` loads `audio` on any clock with `audio_valid`=1. When `audio_valid` coincides with the tick, the tick's mix uses the old `audio_held`.
- **Mix** (registered, clock after `beep_avg` updates):
  - scaled = audio_held >>> (15 − volume), arithmetic shift.
  - b = beep_on ? (signed({1'b0,beep_avg}) − 128) <<< BEEP_SHIFT : 0.
  - sum = scaled + b, computed at 18-bit signed.
  - mix_sat = sum saturated to [−32768, 32767]. `clip`=1 for that one clock if saturation occurred.
- **Gain ramp**: g ∈ 0..16, 5 bits, changes only on ticks.
  - If mute = 0 and g < 16: g increments by 1.
  - If mute = 1 and g > 0: g decrements by 1.
  - Otherwise g holds.
  - Toggling mute mid-ramp reverses direction from the current g, with no jump.
- **Gain stage** (registered, clock after mix): pcm = (mix_sat × g) >>> 4, using a 21-bit signed product. g = 16 is unity.
- **Sigma-delta modulator**, every clock:
  - u = pcm ^ 16'h8000 (offset binary).
  - acc[16:0] <= {1'b0, acc[15:0]} + u.
  - dac_out <= carry of that add, acc[16].
  - Over N clocks with constant pcm, the count of ones = floor-or-ceil of N·u/65536.

## Timing
- Reset values (asynchronous): window counter 0, accumulator 0, beep_avg 128, audio_held 0, mix_sat 0, g 0, pcm 0, sigma-delta acc 0, dac_out 0, clip 0.
- After reset release the output ramps up from silence: g reaches 16 after 16 ticks (512 clocks at the default window).
- Latency from tick clock T:
  - beep_avg valid at T+1.
  - mix_sat and clip at T+2.
  - pcm at T+3.
  - First dac_out bit reflecting the new pcm at T+4.
- g updates at T+1 and is used by the gain stage at T+3.
- `audio_valid` has no handshake; the stage accepts every strobe. Strobes faster than the tick rate overwrite `audio_held`, so only the last sample before a tick is mixed.
- Reset asserted mid-operation clears all state immediately. No partial window survives.

## Structure
- Shared package `audio_pkg`:
  - constants GAIN_MAX = 16, BEEP_MID = 128, PCM_W = 16.
  - a saturation function, sat18to16.
- Sub-module `sd_mod1`: first-order sigma-delta modulator.
  - Ports: clk, rst, pcm[15:0], dac_out.
  - Reused by the other audio pins.

## Test plan
- **Beep only**:
  - Stimulus: beep = 200 constant, beep_on = 1, audio = 0, mute = 0, run 20 ticks.
  - Required: beep_avg = 200, pcm = 4608.
  - Then over 65536 clocks, dac_out has 37376 ± 1 ones.
- **Audio/volume**:
  - Stimulus: audio = −16384 with one strobe, volume = 14, beep_on = 0, g = 16.
  - Required: pcm = −8192; over 65536 clocks, 24576 ± 1 ones.
- **Saturation**:
  - Stimulus: audio = 32767, volume = 15, beep = 255, beep_on = 1.
  - Required: mix_sat = 32767 and clip pulses once per tick, exactly one clock wide.
  - Then set beep = 128: clip stays 0.
- **Mute ramp**:
  - Stimulus: steady pcm = 4608, then assert mute.
  - Required: pcm falls by 288 per tick and reaches 0 after 16 ticks.
  - Deassert mute at g = 8: pcm climbs back from 2304.
- **Coincident strobe**:
  - Stimulus: audio_valid with audio = 1000 on the tick clock; audio_held previously 0; volume = 15, g = 16, beep_on = 0.
  - Required: that tick's pcm = 0; the next tick's pcm = 1000.
- **Reset mid-window**:
  - Stimulus: assert rst at window count 17 with pcm ≠ 0.
  - Required: dac_out = 0, pcm = 0, clip = 0, beep_avg = 128 asynchronously.
  - After release, g re-ramps from 0.
